// File: rtl/hh_neuron_scheduler.sv
// hh_neuron_scheduler
//   Time-multiplexes one shared Hodgkin-Huxley update datapath across
//   NUM_NEURONS logical neurons. Holds per-neuron membrane state and stimulus.
//   Once per timestep it issues one start/done update per neuron in
//   round-robin order, and it collects the spike flags.
//
// Optional feature macro: REFRACTORY_EN
//   Defined  : each neuron has a 2-bit refractory counter that gates its
//              stimulus to 0 for the three updates after a spike.
//   Undefined: dp_stim always equals the stored stimulus.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cfg_we/addr/data  stimulus register write port (accepted in any state)
//   sel               neuron whose state is shown on state_out
//   dp_start          one-cycle launch pulse to the datapath
//   dp_v_in, dp_stim  operands of the slot in flight (stable for the slot)
//   dp_done           datapath result strobe; dp_v_out / dp_spike are valid with it
//   state_out         combinational read of state[sel]
//   spike_vec         spike flags of the most recently completed step
//   step_pulse        one-cycle pulse after the last slot of a step
//   err               sticky: datapath timeout or step overrun
//
// FSM
//   state | meaning
//   IDLE  | waiting for a step request
//   ISSUE | dp_start high, operands of the slot latched
//   WAIT  | waiting for dp_done, bounded by DONE_TIMEOUT cycles
//   WB    | captured result written into the state array
//   NEXT  | advance slot, or close the step (spike_vec, step_pulse)

module hh_neuron_scheduler #(
  parameter int               NUM_NEURONS  = 4,
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] V_REST       = '0,
  parameter int               STEP_DIV     = 16,
  parameter int               DONE_TIMEOUT = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_NEURONS)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]               cfg_data,
  input  logic [$clog2(NUM_NEURONS)-1:0] sel,
  output logic                           dp_start,
  output logic [WIDTH-1:0]               dp_v_in,
  output logic [WIDTH-1:0]               dp_stim,
  input  logic                           dp_done,
  input  logic [WIDTH-1:0]               dp_v_out,
  input  logic                           dp_spike,
  output logic [WIDTH-1:0]               state_out,
  output logic [NUM_NEURONS-1:0]         spike_vec,
  output logic                           step_pulse,
  output logic                           err
);

  localparam int IW  = $clog2(NUM_NEURONS);
  localparam int SCW = $clog2(STEP_DIV);
  localparam int TW  = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, NEXT} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          slot_q, slot_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [SCW-1:0]         step_cnt_q, step_cnt_d;

  logic [WIDTH-1:0]       v_q    [NUM_NEURONS];
  logic [WIDTH-1:0]       stim_q [NUM_NEURONS];
  logic [WIDTH-1:0]       v_lat_q, stim_lat_q;
  logic [WIDTH-1:0]       res_v_q;
  logic                   res_spk_q;
  logic [NUM_NEURONS-1:0] nspike_q, spike_vec_q;
  logic                   step_pulse_q, err_q;

  logic                   step_req, last_slot;
  logic                   latch_en, cap_en, wb_en, abort, step_end, overrun;
  logic [WIDTH-1:0]       v_sel, stim_sel;

`ifdef REFRACTORY_EN
  logic [1:0]             refr_q [NUM_NEURONS];
  assign stim_sel = (refr_q[slot_q] != 2'd0) ? '0 : stim_q[slot_q];
`else
  assign stim_sel = stim_q[slot_q];
`endif

  assign v_sel     = v_q[slot_q];
  assign step_req  = (step_cnt_q == SCW'(STEP_DIV - 1));
  assign last_slot = (slot_q == IW'(NUM_NEURONS - 1));
  assign step_cnt_d = step_req ? '0 : step_cnt_q + SCW'(1);

  // Operands are shown live during ISSUE so they are valid alongside
  // dp_start; afterwards the latched copies hold them for the rest of the slot.
  assign dp_start   = (state_q == ISSUE);
  assign dp_v_in    = dp_start ? v_sel    : v_lat_q;
  assign dp_stim    = dp_start ? stim_sel : stim_lat_q;
  assign state_out  = v_q[sel];
  assign spike_vec  = spike_vec_q;
  assign step_pulse = step_pulse_q;
  assign err        = err_q;

  // The closing NEXT of a step can hand straight over to the next step, so a
  // request landing on that cycle is a back-to-back start rather than an
  // overrun. This is what makes STEP_DIV = 4*NUM_NEURONS sustainable.
  assign overrun = step_req && (state_q != IDLE) && !((state_q == NEXT) && last_slot);

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    tmo_d    = tmo_q;
    latch_en = 1'b0;
    cap_en   = 1'b0;
    wb_en    = 1'b0;
    abort    = 1'b0;
    step_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (step_req) begin
          state_d = ISSUE;
          slot_d  = '0;
        end
      end
      ISSUE: begin
        latch_en = 1'b1;
        tmo_d    = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (dp_done) begin
          cap_en  = 1'b1;
          state_d = WB;
        end else if (tmo_q == TW'(DONE_TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = NEXT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WB: begin
        wb_en   = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        if (last_slot) begin
          step_end = 1'b1;
          slot_d   = '0;
          state_d  = step_req ? ISSUE : IDLE;
        end else begin
          slot_d  = slot_q + IW'(1);
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      tmo_q        <= '0;
      step_cnt_q   <= '0;
      v_lat_q      <= V_REST;
      stim_lat_q   <= '0;
      res_v_q      <= V_REST;
      res_spk_q    <= 1'b0;
      nspike_q     <= '0;
      spike_vec_q  <= '0;
      step_pulse_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      tmo_q      <= tmo_d;
      step_cnt_q <= step_cnt_d;
      if (latch_en) begin
        v_lat_q    <= v_sel;
        stim_lat_q <= stim_sel;
      end
      // dp_v_out is only guaranteed during the dp_done cycle, so hold it for WB
      if (cap_en) begin
        res_v_q   <= dp_v_out;
        res_spk_q <= dp_spike;
      end
      if (wb_en) begin
        nspike_q[slot_q] <= res_spk_q;
      end else if (abort) begin
        nspike_q[slot_q] <= 1'b0;
      end
      if (step_end) begin
        spike_vec_q <= nspike_q;
      end
      step_pulse_q <= step_end;
      if (abort || overrun) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i]    <= V_REST;
        stim_q[i] <= '0;
`ifdef REFRACTORY_EN
        refr_q[i] <= 2'd0;
`endif
      end
    end else begin
      if (cfg_we) begin
        stim_q[cfg_addr] <= cfg_data;
      end
      if (wb_en) begin
        v_q[slot_q] <= res_v_q;
`ifdef REFRACTORY_EN
        if (res_spk_q) begin
          refr_q[slot_q] <= 2'd3;
        end else if (refr_q[slot_q] != 2'd0) begin
          refr_q[slot_q] <= refr_q[slot_q] - 2'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_hh_neuron_scheduler.sv
// Bench for hh_neuron_scheduler: a datapath model answers dp_start after a
// programmable latency (or never, for one chosen neuron), and a transaction
// level reference model predicts slot timing, operands, states and spikes.
module tb_hh_neuron_scheduler;
  localparam int NN = 4;
  localparam int W  = 8;
  localparam int SD = 16;
  localparam int TO = 32;
  localparam int IW = $clog2(NN);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_data = '0;
  logic [IW-1:0] sel = '0;
  logic          dp_start;
  logic [W-1:0]  dp_v_in, dp_stim;
  logic          dp_done = 1'b0;
  logic [W-1:0]  dp_v_out = '0;
  logic          dp_spike = 1'b0;
  logic [W-1:0]  state_out;
  logic [NN-1:0] spike_vec;
  logic          step_pulse, err;

  always #5 clk = ~clk;

  hh_neuron_scheduler #(
    .NUM_NEURONS(NN), .WIDTH(W), .V_REST(8'd0), .STEP_DIV(SD), .DONE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sel(sel), .dp_start(dp_start), .dp_v_in(dp_v_in), .dp_stim(dp_stim),
    .dp_done(dp_done), .dp_v_out(dp_v_out), .dp_spike(dp_spike),
    .state_out(state_out), .spike_vec(spike_vec), .step_pulse(step_pulse), .err(err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model
  int mstate [NN];
  int mstim  [NN];
  int mrefr  [NN];
  bit nspike [NN];
  bit exp_err;
  bit busy;
  int cur_slot;
  int next_evt;
  bit req_busy, req_idle;

  // datapath model
  bit pend;
  int pcnt;
  int lat = 1;
  int drop_slot = -1;
  int lv, ls;
  bit force_done;

  bit wr_req;
  int wr_addr, wr_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_stim(input int n);
`ifdef REFRACTORY_EN
    if (mrefr[n] != 0) return 0;
`endif
    return mstim[n];
  endfunction

  task automatic sweep(input string tag);
    for (int s = 0; s < NN; s++) begin
      sel = IW'(s);
      #1;
      check(tag, 32'(state_out), mstate[s]);
    end
  endtask

  task automatic tick();
    bit exp_start, exp_pulse, accepted;
    int slot, res;
    logic [NN-1:0] es;
    @(negedge clk);
    cyc++;
    cfg_we    = 1'b0;
    dp_done   = 1'b0;
    accepted  = 1'b0;
    if (force_done) begin
      dp_done    = 1'b1;
      dp_v_out   = 8'hA5;
      dp_spike   = 1'b1;
      force_done = 1'b0;
    end else if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        pend = 1'b0;
        res  = (lv + 1 + (ls >> 4)) & 255;
        dp_done  = 1'b1;
        dp_v_out = W'(res);
        dp_spike = (ls >= 'h40);
        check("dp_v_in_hold", 32'(dp_v_in), lv);
        check("dp_stim_hold", 32'(dp_stim), ls);
        mstate[cur_slot] = res;
        nspike[cur_slot] = dp_spike;
        if (dp_spike) mrefr[cur_slot] = 3;
        else if (mrefr[cur_slot] > 0) mrefr[cur_slot]--;
        next_evt = cyc + 3;
      end
    end
    exp_pulse = busy && (next_evt == cyc) && (cur_slot == NN - 1);
    if (req_idle) accepted = 1'b1;
    if (req_busy) begin
      if (exp_pulse) accepted = 1'b1;
      else exp_err = 1'b1;
    end
    req_idle = 1'b0;
    req_busy = 1'b0;
    exp_start = accepted || (busy && (next_evt == cyc) && (cur_slot < NN - 1));
    check("step_pulse", 32'(step_pulse), 32'(exp_pulse));
    check("dp_start", 32'(dp_start), 32'(exp_start));
    if (exp_pulse) begin
      for (int i = 0; i < NN; i++) es[i] = nspike[i];
      check("spike_vec", 32'(spike_vec), 32'(es));
      check("err_at_step", 32'(err), 32'(exp_err));
      sweep("state_at_step");
      busy = 1'b0;
    end
    if (exp_start) begin
      slot = accepted ? 0 : cur_slot + 1;
      cur_slot = slot;
      busy = 1'b1;
      lv = mstate[slot];
      ls = exp_stim(slot);
      check("dp_v_in", 32'(dp_v_in), lv);
      check("dp_stim", 32'(dp_stim), ls);
      if (slot == drop_slot) begin
        nspike[slot] = 1'b0;
        exp_err  = 1'b1;
        next_evt = cyc + TO + 2;
        pend     = 1'b0;
      end else begin
        pend     = 1'b1;
        pcnt     = lat;
        next_evt = -1;
      end
    end
    if (cyc % SD == SD - 1) begin
      if (busy) req_busy = 1'b1;
      else req_idle = 1'b1;
    end
    if (wr_req) begin
      cfg_we   = 1'b1;
      cfg_addr = IW'(wr_addr);
      cfg_data = W'(wr_data);
      mstim[wr_addr] = wr_data & 255;
      wr_req = 1'b0;
    end
  endtask

  task automatic do_reset(input bit late);
    @(negedge clk);
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    dp_done  = late;
    dp_v_out = 8'h5A;
    dp_spike = 1'b1;
    @(negedge clk);
    dp_done = 1'b0;
    check("rst_dp_start", 32'(dp_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < NN; i++) begin
      mstate[i] = 0; mstim[i] = 0; mrefr[i] = 0; nspike[i] = 1'b0;
    end
    exp_err = 1'b0; busy = 1'b0; pend = 1'b0; cur_slot = 0; next_evt = -1;
    req_busy = 1'b0; req_idle = 1'b0; wr_req = 1'b0;
    force_done = late;
    check("rst_step_pulse", 32'(step_pulse), 0);
    check("rst_err", 32'(err), 0);
    check("rst_spike_vec", 32'(spike_vec), 0);
    sweep("rst_state");
  endtask

  task automatic write_stim(input int a, input int d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    tick();
  endtask

  initial begin
    bit found;

    // Reset and first step with all stimuli zero
    lat = 1; drop_slot = -1;
    do_reset(1'b0);
    repeat (33) tick();
    for (int s = 0; s < NN; s++) begin
      sel = IW'(s);
      #1;
      check("step1_state", 32'(state_out), 1);
    end
    check("step1_err", 32'(err), 0);

    // Spike on neuron 2 once its stimulus reaches 0x40
    write_stim(2, 'h40);
    while (cyc < 49) tick();
    check("spike_vec_n2", 32'(spike_vec), 32'(4'b0100));

    // Random stimuli with minimum latency
    for (int i = 0; i < NN; i++) write_stim(i, $urandom_range(0, 255));
    repeat (6 * SD) tick();

    // Stimulus write in the ISSUE cycle of slot 0: old value used now, new next step
    while ((cyc + 1) % SD != 0) tick();
    wr_req = 1'b1; wr_addr = 0; wr_data = (mstim[0] ^ 'h5C) & 255;
    tick();
    check("issue_cycle_start", 32'(dp_start), 1);
    repeat (2 * SD + 2) tick();
    check("no_err_min_latency", 32'(err), 0);

    // Datapath never answers slot 1: timeout, state kept, others still updated
    do_reset(1'b0);
    drop_slot = 1;
    for (int i = 0; i < NN; i++) write_stim(i, $urandom_range(0, 255));
    repeat (120) tick();
    check("timeout_err", 32'(err), 1);
    drop_slot = -1;
    repeat (60) tick();
    check("err_sticky", 32'(err), 1);

    // Reset while slot 2 waits, then a late dp_done
    do_reset(1'b0);
    lat = 2;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (busy && cur_slot == 2 && pend && dp_start === 1'b0) found = 1'b1;
    end
    check("found_wait_slot2", 32'(found), 1);
    do_reset(1'b1);
    lat = 1;
    repeat (3 * SD) tick();

    // Random latency and stimulus
    for (int n = 0; n < 8; n++) begin
      lat = $urandom_range(1, 3);
      write_stim($urandom_range(0, NN - 1), $urandom_range(0, 255));
      repeat (20) tick();
    end

    // Neuron 1 held high so that it spikes repeatedly
    do_reset(1'b0);
    lat = 1;
    write_stim(1, 'hC0);
    repeat (8 * SD) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
